// File: rtl/pong_game_ctrl_if.sv
// Event and status bundle between the pong game sequencer and the video datapath/overlays.
// The datapath side drives frame, button and ball events; the sequencer drives the status back.
interface pong_game_ctrl_if;
  logic       frame_tick;
  logic [1:0] btn;
  logic       hit;
  logic       miss;
  logic [1:0] state;
  logic       graph_still;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [1:0] balls_left;
  logic       show_over;
  logic       timer_busy;

  modport master (
    output frame_tick, btn, hit, miss,
    input  state, graph_still, score_d1, score_d0, balls_left, show_over, timer_busy
  );

  modport slave (
    input  frame_tick, btn, hit, miss,
    output state, graph_still, score_d1, score_d0, balls_left, show_over, timer_busy
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: NEWGAME/PLAY/NEWBALL/OVER control, BCD score, ball count,
// and a frame-counted pause timer. Every output is a register or a decode of registers.
module pong_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int DELAY_FRAMES = 120
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
  localparam logic [7:0] DELAY_INIT  = 8'(DELAY_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] d1_q, d1_d;
  logic [3:0] d0_q, d0_d;
  logic [1:0] balls_q, balls_d;
  logic [7:0] timer_q, timer_d;
  logic       frame_prev_q, frame_prev_d;
  logic       btn_prev_q, btn_prev_d;
  logic       frame_ev;
  logic       btn_ev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= NEWGAME;
      d1_q         <= 4'd0;
      d0_q         <= 4'd0;
      balls_q      <= LIVES_INIT;
      timer_q      <= 8'd0;
      frame_prev_q <= 1'b0;
      btn_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      d1_q         <= d1_d;
      d0_q         <= d0_d;
      balls_q      <= balls_d;
      timer_q      <= timer_d;
      frame_prev_q <= frame_prev_d;
      btn_prev_q   <= btn_prev_d;
    end
  end

  always_comb begin
    frame_ev     = bus.frame_tick & ~frame_prev_q;
    btn_ev       = (|bus.btn) & ~btn_prev_q;
    frame_prev_d = bus.frame_tick;
    btn_prev_d   = |bus.btn;
    state_d      = state_q;
    d1_d         = d1_q;
    d0_d         = d0_q;
    balls_d      = balls_q;
    timer_d      = (frame_ev && timer_q != 8'd0) ? timer_q - 8'd1 : timer_q;

    case (state_q)
      NEWGAME: begin
        if (btn_ev) begin
          state_d = PLAY;
          d1_d    = 4'd0;
          d0_d    = 4'd0;
          balls_d = LIVES_INIT;
        end
      end
      PLAY: begin
        // A miss overrides a simultaneous hit; the load also swallows a coincident frame event.
        if (bus.miss) begin
          balls_d = balls_q - 2'd1;
          timer_d = DELAY_INIT;
          state_d = (balls_q == 2'd1) ? OVER : NEWBALL;
        end else if (bus.hit && !(d1_q == 4'd9 && d0_q == 4'd9)) begin
          if (d0_q == 4'd9) begin
            d0_d = 4'd0;
            d1_d = d1_q + 4'd1;
          end else begin
            d0_d = d0_q + 4'd1;
          end
        end
      end
      NEWBALL: begin
        if (timer_q == 8'd0 && btn_ev) state_d = PLAY;
      end
      OVER: begin
        if (timer_q == 8'd0) state_d = NEWGAME;
      end
      default: state_d = NEWGAME;
    endcase
  end

  assign bus.state       = state_q;
  assign bus.graph_still = (state_q != PLAY);
  assign bus.show_over   = (state_q == OVER);
  assign bus.timer_busy  = (timer_q != 8'd0);
  assign bus.score_d1    = d1_q;
  assign bus.score_d0    = d0_q;
  assign bus.balls_left  = balls_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl with hand-computed expectations.
module tb_pong_game_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   vec_count  = 0;
  int   miscompares = 0;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(.LIVES(3), .DELAY_FRAMES(120)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ft, input logic [1:0] b, input logic h, input logic m);
    bus.frame_tick = ft;
    bus.btn        = b;
    bus.hit        = h;
    bus.miss       = m;
    tick();
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    end
  endtask

  task automatic checkScore(input string tag, input int d1, input int d0);
    checkOutput({tag, "_d1"}, int'(bus.score_d1), d1);
    checkOutput({tag, "_d0"}, int'(bus.score_d0), d0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.btn        = 2'b00;
    bus.hit        = 1'b0;
    bus.miss       = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkOutput("rst_state", int'(bus.state), 0);
    checkScore("rst_score", 0, 0);
    checkOutput("rst_balls", int'(bus.balls_left), 3);
    checkOutput("rst_still", int'(bus.graph_still), 1);
    checkOutput("rst_over", int'(bus.show_over), 0);
    checkOutput("rst_busy", int'(bus.timer_busy), 0);

    // Hits ignored outside PLAY, then first game starts on a button edge
    hits(2);
    checkScore("newgame_hit_ignored", 0, 0);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    checkOutput("start_state", int'(bus.state), 1);
    checkOutput("start_still", int'(bus.graph_still), 0);
    checkOutput("start_balls", int'(bus.balls_left), 3);
    checkScore("start_score", 0, 0);
    idle(1);

    // Score counting with BCD carry and saturation
    hits(9);
    checkScore("score9", 0, 9);
    hits(1);
    checkScore("score10", 1, 0);
    hits(2);
    checkScore("score12", 1, 2);
    hits(87);
    checkScore("score99", 9, 9);
    hits(13);
    checkScore("score_sat", 9, 9);

    // Ball loss into NEWBALL, early button ignored, restart after pause
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("miss1_state", int'(bus.state), 2);
    checkOutput("miss1_balls", int'(bus.balls_left), 2);
    checkOutput("miss1_busy", int'(bus.timer_busy), 1);
    checkOutput("miss1_still", int'(bus.graph_still), 1);
    idle(1);
    frames(119);
    checkOutput("nb_busy119", int'(bus.timer_busy), 1);
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("nb_early_btn", int'(bus.state), 2);
    idle(1);
    frames(1);
    checkOutput("nb_busy120", int'(bus.timer_busy), 0);
    checkOutput("nb_not_queued", int'(bus.state), 2);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    checkOutput("nb_restart", int'(bus.state), 1);
    idle(1);

    // Second ball lost, pause, restart with one ball left
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("miss2_balls", int'(bus.balls_left), 1);
    idle(1);
    frames(120);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    checkOutput("miss2_restart", int'(bus.state), 1);
    idle(1);

    // Last ball lost with a coincident frame edge that the load absorbs
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b1);
    checkOutput("over_state", int'(bus.state), 3);
    checkOutput("over_show", int'(bus.show_over), 1);
    checkOutput("over_balls", int'(bus.balls_left), 0);
    checkOutput("over_busy", int'(bus.timer_busy), 1);
    idle(1);
    hits(1);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    checkOutput("over_btn_ignored", int'(bus.state), 3);
    idle(1);
    frames(119);
    checkOutput("over_busy119", int'(bus.timer_busy), 1);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("over_busy120", int'(bus.timer_busy), 0);
    checkOutput("over_hold", int'(bus.state), 3);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("over_to_newgame", int'(bus.state), 0);
    checkOutput("over_show_off", int'(bus.show_over), 0);
    checkScore("over_retained", 9, 9);
    checkOutput("over_balls_kept", int'(bus.balls_left), 0);

    // New game; simultaneous hit and miss at score 05
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b0);
    checkScore("game2_score", 0, 0);
    checkOutput("game2_balls", int'(bus.balls_left), 3);
    idle(1);
    hits(5);
    checkScore("score05", 0, 5);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1);
    checkScore("hitmiss_score", 0, 5);
    checkOutput("hitmiss_balls", int'(bus.balls_left), 2);
    checkOutput("hitmiss_state", int'(bus.state), 2);
    idle(1);

    // A button held across timer expiry gives no edge
    frames(119);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    checkOutput("held_btn_busy", int'(bus.timer_busy), 0);
    checkOutput("held_btn_no_edge", int'(bus.state), 2);
    idle(1);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    checkOutput("held_btn_release", int'(bus.state), 1);
    idle(1);

    // Mid-game asynchronous reset at score 37
    hits(32);
    checkScore("score37", 3, 7);
    reset = 1'b1;
    #2;
    checkOutput("async_state", int'(bus.state), 0);
    checkScore("async_score", 0, 0);
    checkOutput("async_balls", int'(bus.balls_left), 3);
    checkOutput("async_busy", int'(bus.timer_busy), 0);
    tick();
    reset = 1'b0;

    // A long frame_tick high counts as a single frame event
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("hold_nb_state", int'(bus.state), 2);
    for (int i = 0; i < 500; i++) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    idle(1);
    frames(118);
    checkOutput("hold_busy_after118", int'(bus.timer_busy), 1);
    frames(1);
    checkOutput("hold_busy_after119", int'(bus.timer_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end
endmodule
